svfloat_itof_pipe: RTL and testbench

- Pipelined fixed-point integer to floating-point converter with valid/ready handshake, per-transaction rounding mode, inexact flag and pass-through tag.
- Successor to the combinational integer-to-float converter: same value semantics (in * 2^-frac, optional two's-complement sign), registered and stallable.
- Sits between the integer register file/ALU result bus and the FPU writeback path.

---
 rtl/svfloat_pkg.sv | 33 +++
 rtl/svfloat_lzc.sv | 18 +
 rtl/svfloat_itof_pipe.sv | 174 +++++++++++++++++
 tb/tb_svfloat_itof_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/svfloat_pkg.sv
// Shared float formats, rounding-mode encoding and exponent sizing for the svfloat blocks.
package svfloat;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float32;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
    } float16;

    typedef logic [2:0] rmode_t;

    localparam rmode_t RM_RNE = 3'd0;
    localparam rmode_t RM_RTZ = 3'd1;
    localparam rmode_t RM_RDN = 3'd2;
    localparam rmode_t RM_RUP = 3'd3;
    localparam rmode_t RM_RMM = 3'd4;

    // Signed width wide enough for the unbiased exponent of any width-bit integer.
    function automatic int exp_width(input int width, input int exp_bits);
        int a;
        int b;
        a = $clog2(width) + 1;
        b = exp_bits + 1;
        return ((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/svfloat_lzc.sv
// Combinational leading-zero counter; yields width for an all-zero input.
module svfloat_lzc #(
    parameter int width = 32
) (
    input  logic [width-1:0]             value,
    output logic [$clog2(width+1)-1:0]   count
);
    localparam int CW = $clog2(width + 1);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CW'(width);
        for (int i = 0; i < width; i++) begin
            if (value[i]) count = CW'(width - 1 - i);
        end
    end

endmodule

// File: rtl/svfloat_itof_pipe.sv
// Three-stage stallable fixed-point to float converter with per-transaction rounding mode.
module svfloat_itof_pipe
    import svfloat::*;
#(
    parameter type float = svfloat::float32,
    parameter int  width = 32,
    parameter int  frac  = 0,
    parameter int  tag_w = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [width-1:0]         in_data,
    input  logic                     in_signed,
    input  logic [2:0]               in_rm,
    input  logic [tag_w-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$bits(float)-1:0]  out_data,
    output logic                     out_inexact,
    output logic                     out_overflow,
    output logic [tag_w-1:0]         out_tag
);
    localparam float F0   = '0;
    localparam int   EB   = $bits(F0.exp);
    localparam int   MB   = $bits(F0.man);
    localparam int   EW   = exp_width(width, EB);
    localparam int   CW   = $clog2(width + 1);
    localparam int   L    = width + MB + 3;
    localparam int   BIAS = (1 << (EB - 1)) - 1;

    logic v1, v2, v3;
    logic adv1, adv2, adv3, accept;

    logic               s1_sign;
    logic [width-1:0]   s1_mag;
    rmode_t             s1_rm;
    logic [tag_w-1:0]   s1_tag;

    logic               s2_sign, s2_zero;
    logic [width-1:0]   s2_man;
    logic signed [EW-1:0] s2_exp;
    rmode_t             s2_rm;
    logic [tag_w-1:0]   s2_tag;

    logic               in_neg;
    logic [width-1:0]   in_mag;
    logic [CW-1:0]      lzc;
    logic [width-1:0]   norm;
    logic signed [EW-1:0] exp_d;

    float               res;
    logic               res_inx, res_ovf;

    assign adv3      = v3 && out_ready;
    assign adv2      = v2 && (!v3 || adv3);
    assign adv1      = v1 && (!v2 || adv2);
    assign in_ready  = !v1 || adv1;
    assign accept    = in_valid && in_ready;
    assign out_valid = v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= accept || (v1 && !adv1);
            v2 <= adv1 || (v2 && !adv2);
            v3 <= adv2 || (v3 && !adv3);
        end
    end

    // S1: sign/magnitude split; the most negative value negates to itself, which is the right magnitude.
    assign in_neg = in_signed && in_data[width-1];
    assign in_mag = in_neg ? -in_data : in_data;

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_sign <= in_neg;
            s1_mag  <= in_mag;
            s1_rm   <= in_rm;
            s1_tag  <= in_tag;
        end
    end

    // S2: normalise so the leading one sits in the msb.
    svfloat_lzc #(.width(width)) u_lzc (
        .value (s1_mag),
        .count (lzc)
    );

    assign norm  = s1_mag << lzc;
    assign exp_d = $signed(EW'(width - 1 - frac)) - $signed(EW'(lzc));

    always_ff @(posedge clk) begin
        if (adv1) begin
            s2_sign <= s1_sign;
            s2_zero <= (s1_mag == '0);
            s2_man  <= norm;
            s2_exp  <= exp_d;
            s2_rm   <= s1_rm;
            s2_tag  <= s1_tag;
        end
    end

    // S3: denormalising shift, rounding, renormalisation and packing.
    logic [L-1:0]   val, shifted, mask;
    logic [MB:0]    kept;
    logic [MB+1:0]  sum;
    logic           rnd, stk, inc;
    int             be_i, sh_i, ef;

    always_comb begin
        be_i    = int'(s2_exp) + BIAS;
        sh_i    = (be_i < 1) ? (1 - be_i) : 0;
        if (sh_i > MB + 2) sh_i = MB + 2;
        val     = {s2_man, {(MB + 3){1'b0}}};
        mask    = ~({L{1'b1}} << sh_i);
        shifted = val >> sh_i;
        kept    = shifted[L-1 -: MB+1];
        rnd     = shifted[L-MB-2];
        stk     = (|shifted[L-MB-3:0]) || (|(val & mask));
        case (s2_rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s2_sign && (rnd || stk);
            RM_RUP:  inc = !s2_sign && (rnd || stk);
            RM_RMM:  inc = rnd;
            default: inc = rnd && (stk || kept[0]);
        endcase
        sum = {1'b0, kept} + {{(MB + 1){1'b0}}, inc};
        // A subnormal that rounds into bit MB becomes the smallest normal.
        if (sh_i == 0) ef = be_i + int'(sum[MB+1]);
        else           ef = sum[MB] ? 1 : 0;

        res      = '0;
        res.sign = s2_sign;
        res.exp  = EB'(ef);
        res.man  = sum[MB-1:0];
        res_inx  = rnd || stk;
        res_ovf  = 1'b0;
        if (s2_zero) begin
            res     = '0;
            res_inx = 1'b0;
        end else if (ef >= (1 << EB) - 1) begin
            res_ovf = 1'b1;
            res_inx = 1'b1;
            res.exp = '1;
            res.man = '0;
            if ((s2_rm == RM_RTZ) ||
                (s2_rm == RM_RUP && s2_sign) ||
                (s2_rm == RM_RDN && !s2_sign)) begin
                res.exp = {{(EB - 1){1'b1}}, 1'b0};
                res.man = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data     <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
            out_tag      <= '0;
        end else if (adv2) begin
            out_data     <= res;
            out_inexact  <= res_inx;
            out_overflow <= res_ovf;
            out_tag      <= s2_tag;
        end
    end

endmodule

// File: tb/tb_svfloat_itof_pipe.sv
// Scoreboard bench for svfloat_itof_pipe across float32/float16 and a fractional-input configuration.
module tb_svfloat_itof_pipe;
    import svfloat::*;

    typedef struct packed {
        logic [31:0] d;
        logic        inx;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_signed;
    logic [2:0]  in_rm;
    logic [3:0]  in_tag;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_inexact_a, out_overflow_a;
    logic [31:0] in_data_a, out_data_a;
    logic [3:0]  out_tag_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_inexact_b, out_overflow_b;
    logic [31:0] in_data_b;
    logic [15:0] out_data_b;
    logic [3:0]  out_tag_b;

    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_inexact_c, out_overflow_c;
    logic [15:0] in_data_c;
    logic [31:0] out_data_c;
    logic [3:0]  out_tag_c;

    svfloat_itof_pipe #(.float(svfloat::float32), .width(32), .frac(0), .tag_w(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_inexact(out_inexact_a),
        .out_overflow(out_overflow_a), .out_tag(out_tag_a));

    svfloat_itof_pipe #(.float(svfloat::float16), .width(32), .frac(0), .tag_w(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_inexact(out_inexact_b),
        .out_overflow(out_overflow_b), .out_tag(out_tag_b));

    svfloat_itof_pipe #(.float(svfloat::float32), .width(16), .frac(15), .tag_w(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
        .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag), .out_valid(out_valid_c),
        .out_ready(out_ready_c), .out_data(out_data_c), .out_inexact(out_inexact_c),
        .out_overflow(out_overflow_c), .out_tag(out_tag_c));

    exp_t q0[$], q1[$], q2[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, acc_cyc = 0;
    bit   rec_out = 1'b0;
    int   out_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Exact float32 encoding of a small positive integer.
    function automatic logic [31:0] ref32(input int unsigned n);
        int k = 0;
        for (int i = 0; i < 32; i++) if (n[i]) k = i;
        return {1'b0, 8'(127 + k), 23'(n << (23 - k))};
    endfunction

    task automatic score(input int k, input logic [31:0] d, input logic inx, input logic ovf,
                         input logic [3:0] tg);
        exp_t e;
        int   sz;
        sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            chk($sformatf("spurious_out%0d_t%0h", k, tg), 32'(sz), 32'd1);
            return;
        end
        if (k == 0) e = q0.pop_front();
        else if (k == 1) e = q1.pop_front();
        else e = q2.pop_front();
        chk($sformatf("data%0d_t%0h", k, e.tag), d, e.d);
        chk($sformatf("inexact%0d_t%0h", k, e.tag), 32'(inx), 32'(e.inx));
        chk($sformatf("overflow%0d_t%0h", k, e.tag), 32'(ovf), 32'(e.ovf));
        chk($sformatf("tag%0d_t%0h", k, e.tag), 32'(tg), 32'(e.tag));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a && out_ready_a) begin
                score(0, out_data_a, out_inexact_a, out_overflow_a, out_tag_a);
                if (rec_out) out_cyc.push_back(cyc);
            end
            if (out_valid_b && out_ready_b)
                score(1, {16'd0, out_data_b}, out_inexact_b, out_overflow_b, out_tag_b);
            if (out_valid_c && out_ready_c)
                score(2, out_data_c, out_inexact_c, out_overflow_c, out_tag_c);
        end
    end

    function automatic logic rdy(input int k);
        return (k == 0) ? in_ready_a : (k == 1) ? in_ready_b : in_ready_c;
    endfunction

    task automatic idle();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_valid_c = 1'b0;
    endtask

    task automatic drive(input int k, input logic [31:0] d, input logic sg, input logic [2:0] rm,
                         input logic [3:0] tg, input logic [31:0] ed, input logic ei, input logic eo);
        exp_t e;
        bit   ok = 1'b0;
        in_data_a  = d;
        in_data_b  = d;
        in_data_c  = d[15:0];
        in_signed  = sg;
        in_rm      = rm;
        in_tag     = tg;
        in_valid_a = (k == 0);
        in_valid_b = (k == 1);
        in_valid_c = (k == 2);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rdy(k)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk($sformatf("accept_timeout%0d_t%0h", k, tg), 32'(ok), 32'd1);
        else begin
            e = '{d: ed, inx: ei, ovf: eo, tag: tg};
            if (k == 0) q0.push_back(e);
            else if (k == 1) q1.push_back(e);
            else q2.push_back(e);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (q0.size() + q1.size() + q2.size()) != 0; n++) @(posedge clk);
        #1;
    endtask

    int first_acc;

    initial begin
        rst = 1'b1;
        idle();
        in_data_a = '0; in_data_b = '0; in_data_c = '0;
        in_signed = 1'b0; in_rm = RM_RNE; in_tag = '0;
        out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_a", 32'(in_ready_a), 32'd1);
        chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        chk("rst_out_data_a", out_data_a, 32'd0);
        chk("rst_out_tag_a", 32'(out_tag_a), 32'd0);
        chk("rst_in_ready_b", 32'(in_ready_b), 32'd1);
        chk("rst_out_valid_c", 32'(out_valid_c), 32'd0);
        @(posedge clk);
        #1;

        // float32, width 32, integer input
        drive(0, 32'h0000_0001, 0, RM_RNE, 4'h1, 32'h3F80_0000, 0, 0);
        drive(0, 32'hFFFF_FFFF, 1, RM_RNE, 4'h2, 32'hBF80_0000, 0, 0);
        drive(0, 32'h8000_0000, 1, RM_RNE, 4'h3, 32'hCF00_0000, 0, 0);
        drive(0, 32'h0100_0001, 0, RM_RNE, 4'h4, 32'h4B80_0000, 1, 0);
        drive(0, 32'h0100_0001, 0, RM_RUP, 4'h5, 32'h4B80_0001, 1, 0);
        drive(0, 32'h0100_0001, 0, RM_RTZ, 4'h6, 32'h4B80_0000, 1, 0);
        drive(0, 32'hFEFF_FFFF, 1, RM_RDN, 4'h7, 32'hCB80_0001, 1, 0);
        drive(0, 32'h0100_0001, 0, RM_RDN, 4'h8, 32'h4B80_0000, 1, 0);
        drive(0, 32'h0100_0001, 0, RM_RMM, 4'h9, 32'h4B80_0001, 1, 0);
        drive(0, 32'h0100_0003, 0, 3'd6,   4'hA, 32'h4B80_0002, 1, 0);
        drive(0, 32'hFFFF_FFFF, 0, RM_RNE, 4'hB, 32'h4F80_0000, 1, 0);
        drive(0, 32'h0000_0000, 1, RM_RDN, 4'hC, 32'h0000_0000, 0, 0);
        // float16 with overflow in every rounding direction
        drive(1, 32'd70000,     0, RM_RNE, 4'h1, 32'h7C00, 1, 1);
        drive(1, 32'd70000,     0, RM_RTZ, 4'h2, 32'h7BFF, 1, 1);
        drive(1, 32'd70000,     0, RM_RUP, 4'h3, 32'h7C00, 1, 1);
        drive(1, 32'd70000,     0, RM_RDN, 4'h4, 32'h7BFF, 1, 1);
        drive(1, 32'hFFFE_EE90, 1, RM_RUP, 4'h5, 32'hFBFF, 1, 1);
        drive(1, 32'hFFFE_EE90, 1, RM_RDN, 4'h6, 32'hFC00, 1, 1);
        drive(1, 32'd0,         0, RM_RNE, 4'h7, 32'h0000, 0, 0);
        drive(1, 32'd65504,     0, RM_RNE, 4'h8, 32'h7BFF, 0, 0);
        drive(1, 32'd65520,     0, RM_RNE, 4'h9, 32'h7C00, 1, 1);
        drive(1, 32'd2049,      0, RM_RNE, 4'hA, 32'h6800, 1, 0);
        // float32, 16-bit input with 15 fractional bits
        drive(2, 32'h0001, 0, RM_RNE, 4'h1, 32'h3800_0000, 0, 0);
        drive(2, 32'h8000, 1, RM_RNE, 4'h2, 32'hBF80_0000, 0, 0);
        drive(2, 32'h7FFF, 0, RM_RNE, 4'h3, 32'h3F7F_FE00, 0, 0);
        idle();
        drain();

        // back-to-back throughput
        out_cyc.delete();
        rec_out = 1'b1;
        first_acc = 0;
        for (int i = 1; i <= 8; i++) begin
            drive(0, 32'(i), 0, RM_RNE, 4'(i), ref32(i), 0, 0);
            if (i == 1) first_acc = acc_cyc;
        end
        idle();
        drain();
        rec_out = 1'b0;
        chk("thru_in_span", 32'(acc_cyc - first_acc), 32'd7);
        chk("thru_out_count", 32'(out_cyc.size()), 32'd8);
        if (out_cyc.size() == 8) chk("thru_out_span", 32'(out_cyc[7] - out_cyc[0]), 32'd7);

        // backpressure: three accepts fill the pipe, then stall five cycles
        out_ready_a = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 32'(10 + i), 0, RM_RNE, 4'(i), ref32(10 + i), 0, 0);
        in_data_a = 32'd13;
        in_tag    = 4'd3;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready_a), 32'd0);
            chk("stall_out_valid", 32'(out_valid_a), 32'd1);
            chk("stall_out_tag", 32'(out_tag_a), 32'd0);
            chk("stall_out_data", out_data_a, ref32(10));
        end
        @(posedge clk);
        #1 out_ready_a = 1'b1;
        for (int i = 3; i < 8; i++) drive(0, 32'(10 + i), 0, RM_RNE, 4'(i), ref32(10 + i), 0, 0);
        idle();
        drain();

        // reset with three transactions in flight
        out_ready_a = 1'b0;
        drive(0, 32'd100, 0, RM_RNE, 4'hD, ref32(100), 0, 0);
        drive(0, 32'd101, 0, RM_RNE, 4'hE, ref32(101), 0, 0);
        drive(0, 32'd102, 0, RM_RNE, 4'hF, ref32(102), 0, 0);
        idle();
        rst = 1'b1;
        q0.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
        chk("midrst_in_ready", 32'(in_ready_a), 32'd1);
        out_ready_a = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        drive(0, 32'd5, 0, RM_RNE, 4'h1, ref32(5), 0, 0);
        idle();
        drain();

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("q2_empty", 32'(q2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
